// File: rtl/ultrasonic_burst_transmitter.sv
// Ultrasonic burst transmitter: complementary H-bridge drive with dead time,
// single-shot or free-running bursts at a fixed minimum start-to-start period.
module ultrasonic_burst_transmitter #(
   parameter int HALF_PERIOD  = 625,
   parameter int DEAD_TIME    = 12,
   parameter int BURST_CYCLES = 8,
   parameter int REPEAT_CLKS  = 1000000,
   parameter int CNT_W        = 24
) (
   input  logic        sys_clk_i,
   input  logic        rst_n_i,
   input  logic        on_i,
   input  logic        trigger_i,
   input  logic        auto_i,
   output logic        tx_p_o,
   output logic        tx_n_o,
   output logic        burst_sent_o,
   output logic        busy_o,
   output logic [15:0] burst_count_o
);

   localparam int HALVES = 2 * BURST_CYCLES;
   localparam int HW     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int NW     = (HALVES > 1) ? $clog2(HALVES) : 1;

   localparam logic [HW-1:0]    H_LAST = HW'(HALF_PERIOD - 1);
   localparam logic [HW-1:0]    DEAD_V = HW'(DEAD_TIME);
   localparam logic [NW-1:0]    N_LAST = NW'(HALVES - 1);
   localparam logic [CNT_W-1:0] P_LAST = CNT_W'(REPEAT_CLKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      HOLDOFF
   } state_t;

   state_t           state_q, state_d;
   logic [HW-1:0]    h_q, h_d;
   logic [NW-1:0]    half_q, half_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [15:0]      count_q, count_d;
   logic             tx_p_q, tx_p_d;
   logic             tx_n_q, tx_n_d;
   logic             sent_q, sent_d;
   logic             busy_q, busy_d;

   logic             launch;
   logic [CNT_W-1:0] pcnt_inc;

   assign launch   = on_i & (trigger_i | auto_i);
   assign pcnt_inc = (pcnt_q >= P_LAST) ? pcnt_q : pcnt_q + 1'b1;

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         h_q     <= '0;
         half_q  <= '0;
         pcnt_q  <= '0;
         count_q <= '0;
         tx_p_q  <= 1'b0;
         tx_n_q  <= 1'b0;
         sent_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         half_q  <= half_d;
         pcnt_q  <= pcnt_d;
         count_q <= count_d;
         tx_p_q  <= tx_p_d;
         tx_n_q  <= tx_n_d;
         sent_q  <= sent_d;
         busy_q  <= busy_d;
      end
   end

   // The last HOLDOFF cycle doubles as the IDLE sampling point, which keeps
   // held-AUTO burst starts exactly REPEAT_CLKS apart.
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      half_d  = half_q;
      pcnt_d  = pcnt_q;
      count_d = count_q;
      sent_d  = 1'b0;

      if (!on_i) begin
         state_d = IDLE;
         h_d     = '0;
         half_d  = '0;
         pcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (launch) begin
                  state_d = DRIVE;
                  h_d     = '0;
                  half_d  = '0;
                  pcnt_d  = '0;
                  sent_d  = 1'b1;
                  count_d = count_q + 16'd1;
               end
            end
            DRIVE: begin
               pcnt_d = pcnt_inc;
               if (h_q == H_LAST) begin
                  h_d = '0;
                  if (half_q == N_LAST) begin
                     state_d = HOLDOFF;
                     half_d  = '0;
                  end else begin
                     half_d = half_q + 1'b1;
                  end
               end else begin
                  h_d = h_q + 1'b1;
               end
            end
            HOLDOFF: begin
               pcnt_d = pcnt_inc;
               if (pcnt_q >= P_LAST) begin
                  if (launch) begin
                     state_d = DRIVE;
                     h_d     = '0;
                     half_d  = '0;
                     pcnt_d  = '0;
                     sent_d  = 1'b1;
                     count_d = count_q + 16'd1;
                  end else begin
                     state_d = IDLE;
                     h_d     = '0;
                     half_d  = '0;
                     pcnt_d  = '0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               h_d     = '0;
               half_d  = '0;
               pcnt_d  = '0;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
      tx_p_d = (state_d == DRIVE) && !half_d[0] && (h_d >= DEAD_V);
      tx_n_d = (state_d == DRIVE) &&  half_d[0] && (h_d >= DEAD_V);
   end

   assign tx_p_o        = tx_p_q;
   assign tx_n_o        = tx_n_q;
   assign burst_sent_o  = sent_q;
   assign busy_o        = busy_q;
   assign burst_count_o = count_q;

endmodule

// File: tb/tb_ultrasonic_burst_transmitter.sv
// Randomized scoreboard bench for ultrasonic_burst_transmitter: a cycle model
// derived from burst timing arithmetic feeds a queue drained by a monitor.
module tb_ultrasonic_burst_transmitter;

   localparam int HP  = 4;
   localparam int DT  = 1;
   localparam int BC  = 2;
   localparam int RC  = 40;
   localparam int DRV = 2 * BC * HP;
   localparam int BL  = (RC > DRV) ? RC : DRV + 1;

   typedef struct packed {
      logic        p;
      logic        n;
      logic        s;
      logic        b;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        on;
   logic        trig;
   logic        autoMode;
   logic        txP;
   logic        txN;
   logic        sent;
   logic        busy;
   logic [15:0] count;

   int          errors = 0;
   int          checks = 0;
   bit          checkEn = 1'b0;
   exp_t        expQ[$];

   bit          mBusy;
   int          mC;
   logic [15:0] mCount;
   logic        mSent;

   ultrasonic_burst_transmitter #(
      .HALF_PERIOD (HP),
      .DEAD_TIME   (DT),
      .BURST_CYCLES(BC),
      .REPEAT_CLKS (RC),
      .CNT_W       (24)
   ) dut (
      .sys_clk_i    (clk),
      .rst_n_i      (rst_n),
      .on_i         (on),
      .trigger_i    (trig),
      .auto_i       (autoMode),
      .tx_p_o       (txP),
      .tx_n_o       (txN),
      .burst_sent_o (sent),
      .busy_o       (busy),
      .burst_count_o(count)
   );

   always #5 clk = ~clk;

   // Expected outputs for the cycle the model currently describes.
   function automatic exp_t expected();
      exp_t e;
      bit   drv;
      drv   = mBusy && (mC < DRV);
      e.p   = drv && ((mC / HP) % 2 == 0) && ((mC % HP) >= DT);
      e.n   = drv && ((mC / HP) % 2 == 1) && ((mC % HP) >= DT);
      e.s   = mSent;
      e.b   = mBusy;
      e.cnt = mCount;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit o, input bit t, input bit a, input int n);
      on       = o;
      trig     = t;
      autoMode = a;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Reference model: a burst occupies BL cycles; the last of them accepts a relaunch.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mBusy  = 1'b0;
            mC     = 0;
            mCount = '0;
            mSent  = 1'b0;
            expQ.delete();
         end else begin
            mSent = 1'b0;
            if (!on) begin
               mBusy = 1'b0;
               mC    = 0;
            end else if (!mBusy || mC == BL - 1) begin
               if (trig || autoMode) begin
                  mBusy  = 1'b1;
                  mC     = 0;
                  mSent  = 1'b1;
                  mCount = mCount + 16'd1;
               end else begin
                  mBusy = 1'b0;
                  mC    = 0;
               end
            end else begin
               mC++;
            end
         end
         expQ.push_back(expected());
      end
   end

   // Monitor: compare the DUT against the oldest pending expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() == 0) begin
            if (checkEn) begin
               checks++;
               errors++;
               $display("[TB] FAIL queue at %0t: got empty expected entry", $time);
            end
         end else begin
            e = expQ.pop_front();
            if (checkEn) begin
               checkOutput("tx_p", {15'd0, txP}, {15'd0, e.p});
               checkOutput("tx_n", {15'd0, txN}, {15'd0, e.n});
               checkOutput("burstSent", {15'd0, sent}, {15'd0, e.s});
               checkOutput("busy", {15'd0, busy}, {15'd0, e.b});
               checkOutput("count", count, e.cnt);
               checkOutput("overlap", {15'd0, txP & txN}, 16'd0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit mode;
      rst_n    = 1'b0;
      on       = 1'b0;
      trig     = 1'b0;
      autoMode = 1'b0;
      @(posedge clk);
      #2;
      checkEn = 1'b1;
      applyStimulus(0, 0, 0, 2);
      rst_n = 1'b1;
      applyStimulus(1, 0, 0, 3);

      // Single trigger pulse
      applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 0, 0, 45);

      // AUTO held for three bursts
      applyStimulus(1, 0, 1, 120);
      applyStimulus(1, 0, 0, 45);

      // Triggers during a burst are ignored
      applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 0, 0, 4);
      applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 0, 0, 24);
      applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 0, 0, 20);

      // ON dropped mid-burst, then relaunch
      applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 0, 0, 6);
      applyStimulus(0, 0, 0, 3);
      applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 0, 0, 45);

      // Asynchronous reset mid-drive with launch requests held
      applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 0, 0, 5);
      on       = 1'b1;
      trig     = 1'b1;
      autoMode = 1'b1;
      rst_n    = 1'b0;
      #1;
      checkOutput("rst_tx_p", {15'd0, txP}, 16'd0);
      checkOutput("rst_tx_n", {15'd0, txN}, 16'd0);
      checkOutput("rst_busy", {15'd0, busy}, 16'd0);
      checkOutput("rst_count", count, 16'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1, 0, 0, 45);

      // Burst counter wrap
      checkEn = 1'b0;
      dut.count_q = 16'hFFFE;
      mCount      = 16'hFFFE;
      @(posedge clk);
      #2;
      checkEn = 1'b1;
      applyStimulus(1, 0, 1, 80);
      applyStimulus(1, 0, 0, 45);
      checkOutput("wrap_count", count, 16'h0000);

      // Randomized traffic
      mode = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (i % 250 == 0) mode = 1'($urandom_range(0, 1));
         applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0, mode, 1);
      end
      applyStimulus(1, 0, 0, 45);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
